// File: rtl/weight_bit_serializer_pkg.sv
// Shared definitions for the bit-serial weight transmitter: precision bounds,
// FSM encoding and the precision clamp used at word accept.
package weight_bit_serializer_pkg;

  localparam int PREC_MIN = 2;
  localparam int PREC_MAX = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Clamps a requested precision into [lo, hi] and returns the MSB index (P-1),
  // which is what the shifter actually needs to store per word.
  function automatic logic [2:0] prec_msb(input logic [3:0] p, input int lo, input int hi);
    int c;
    c = int'(p);
    if (c < lo) c = lo;
    else if (c > hi) c = hi;
    return 3'(c - 1);
  endfunction

endpackage

// File: rtl/weight_bit_serializer_buffer.sv
// One-entry pending word register with a full flag; loaded while a word is
// shifting and drained into the active slot at the last-bit edge.
module serial_word_buffer
  import weight_bit_serializer_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 drain,
  input  logic [ACT_WIDTH-1:0] d_act,
  input  logic [W_WIDTH-1:0]   d_w,
  input  logic [2:0]           d_msb,
  output logic                 full,
  output logic [ACT_WIDTH-1:0] q_act,
  output logic [W_WIDTH-1:0]   q_w,
  output logic [2:0]           q_msb
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by full, so it needs no reset; only the flag does.
  always_ff @(posedge clk) begin
    if (load) begin
      q_act <= d_act;
      q_w   <= d_w;
      q_msb <= d_msb;
    end
  end

endmodule

// File: rtl/weight_bit_serializer.sv
// Bit-serial weight transmitter: accepts {FP16 activation, INT weight} words and
// emits the weight MSB-first, one bit per cycle, with gapless back-to-back words.
module weight_bit_serializer
  import weight_bit_serializer_pkg::*;
#(
  parameter int ACT_WIDTH     = 16,
  parameter int MAX_PRECISION = PREC_MAX,
  parameter int MIN_PRECISION = PREC_MIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [3:0]               precision,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACT_WIDTH-1:0]     in_act,
  input  logic [MAX_PRECISION-1:0] in_w,
  output logic [ACT_WIDTH-1:0]     act,
  output logic                     w,
  output logic                     valid,
  output logic                     first,
  output logic                     last,
  output logic [2:0]               bit_idx
);

  state_t                   state, state_next;
  logic [2:0]               bit_idx_next;
  logic [ACT_WIDTH-1:0]     active_act;
  logic [MAX_PRECISION-1:0] active_w;
  logic [2:0]               active_msb;
  logic [2:0]               in_msb;

  logic                     pend_full, pend_load, pend_drain;
  logic [ACT_WIDTH-1:0]     pend_act;
  logic [MAX_PRECISION-1:0] pend_w;
  logic [2:0]               pend_msb;

  logic accept, at_last, load_in, load_pend;

  assign in_msb   = prec_msb(precision, MIN_PRECISION, MAX_PRECISION);
  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready && !clear;
  assign at_last  = (state == SHIFT) && (bit_idx == active_msb);

  serial_word_buffer #(
    .ACT_WIDTH(ACT_WIDTH),
    .W_WIDTH  (MAX_PRECISION)
  ) u_pending (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .load  (pend_load),
    .drain (pend_drain),
    .d_act (in_act),
    .d_w   (in_w),
    .d_msb (in_msb),
    .full  (pend_full),
    .q_act (pend_act),
    .q_w   (pend_w),
    .q_msb (pend_msb)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    load_in      = 1'b0;
    load_pend    = 1'b0;
    pend_load    = 1'b0;
    pend_drain   = 1'b0;
    if (clear) begin
      state_next   = IDLE;
      bit_idx_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            load_in      = 1'b1;
            state_next   = SHIFT;
            bit_idx_next = '0;
          end
        end
        SHIFT: begin
          if (at_last) begin
            // Refill from pending first, else bypass a word arriving this edge.
            bit_idx_next = '0;
            if (pend_full) begin
              load_pend  = 1'b1;
              pend_drain = 1'b1;
            end else if (accept) begin
              load_in = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            pend_load    = accept;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      active_act <= '0;
      active_w   <= '0;
      active_msb <= '0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      if (load_in) begin
        active_act <= in_act;
        active_w   <= in_w;
        active_msb <= in_msb;
      end else if (load_pend) begin
        active_act <= pend_act;
        active_w   <= pend_w;
        active_msb <= pend_msb;
      end
    end
  end

  assign valid = (state == SHIFT);
  assign first = valid && (bit_idx == 3'd0);
  assign last  = at_last;
  assign w     = valid && active_w[active_msb - bit_idx];
  assign act   = active_act;

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed bench for weight_bit_serializer: a per-cycle vector table plus
// hand-written async-reset and three-word streaming sequences.
module tb_weight_bit_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  precision;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_w;
  logic [15:0] act;
  logic        w, valid, first, last;
  logic [2:0]  bit_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weight_bit_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .precision(precision),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_act   (in_act),
    .in_w     (in_w),
    .act      (act),
    .w        (w),
    .valid    (valid),
    .first    (first),
    .last     (last),
    .bit_idx  (bit_idx)
  );

  typedef struct {
    logic        clr;
    logic        iv;
    logic [3:0]  prec;
    logic [7:0]  iw;
    logic [15:0] iact;
    logic        e_valid;
    logic        e_w;
    logic        e_first;
    logic        e_last;
    logic [2:0]  e_idx;
    logic        e_ready;
    logic [15:0] e_act;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic clr, input logic iv, input logic [3:0] prec, input logic [7:0] iw,
                     input logic [15:0] iact, input logic ev, input logic ew, input logic ef,
                     input logic el, input logic [2:0] ei, input logic er, input logic [15:0] ea);
    vec_t v;
    v = '{clr, iv, prec, iw, iact, ev, ew, ef, el, ei, er, ea};
    vecs.push_back(v);
  endtask

  // Idle-output vector: no input activity, stream off.
  task automatic add_idle(input logic [3:0] prec, input logic er, input logic [15:0] ea);
    add(0, 0, prec, 8'h00, 16'h0000, 0, 0, 0, 0, 3'd0, er, ea);
  endtask

  typedef struct { logic [3:0] p; logic [7:0] w; logic [15:0] a; } word_t;
  typedef struct { logic w; logic f; logic l; logic [15:0] a; } bit_t;

  initial begin
    word_t words[3];
    bit_t  exp_q[$];
    int k, got, first_v, last_v, w3_edge;
    logic acc;

    rst = 1'b0; clear = 1'b0; precision = 4'd4; in_valid = 1'b0; in_act = '0; in_w = '0;
    #12;
    check("reset act", act, 0);
    check("reset w", w, 0);
    check("reset valid", valid, 0);
    check("reset first", first, 0);
    check("reset last", last, 0);
    check("reset bit_idx", bit_idx, 0);
    check("reset in_ready", in_ready, 1);
    @(posedge clk); #1; rst = 1'b1;

    // Single word P=4, w=1011
    add(0, 1, 4, 8'h0B, 16'h3C00, 1, 1, 1, 0, 3'd0, 1, 16'h3C00);
    add(0, 0, 4, 8'h00, 16'h0000, 1, 0, 0, 0, 3'd1, 1, 16'h3C00);
    add(0, 0, 4, 8'h00, 16'h0000, 1, 1, 0, 0, 3'd2, 1, 16'h3C00);
    add(0, 0, 4, 8'h00, 16'h0000, 1, 1, 0, 1, 3'd3, 1, 16'h3C00);
    add_idle(4, 1, 16'h3C00);
    // Back-to-back P=3: 011 then 100 via pending
    add(0, 1, 3, 8'h03, 16'h1111, 1, 0, 1, 0, 3'd0, 1, 16'h1111);
    add(0, 1, 3, 8'h04, 16'h2222, 1, 1, 0, 0, 3'd1, 0, 16'h1111);
    add(0, 0, 3, 8'h00, 16'h0000, 1, 1, 0, 1, 3'd2, 0, 16'h1111);
    add(0, 0, 3, 8'h00, 16'h0000, 1, 1, 1, 0, 3'd0, 1, 16'h2222);
    add(0, 0, 3, 8'h00, 16'h0000, 1, 0, 0, 0, 3'd1, 1, 16'h2222);
    add(0, 0, 3, 8'h00, 16'h0000, 1, 0, 0, 1, 3'd2, 1, 16'h2222);
    add_idle(3, 1, 16'h2222);
    // Precision change during shift; B bypasses pending at A's last-bit edge
    add(0, 1, 8, 8'h81, 16'h4444, 1, 1, 1, 0, 3'd0, 1, 16'h4444);
    for (int i = 1; i <= 6; i++) add(0, 0, 2, 8'h00, 16'h0000, 1, 0, 0, 0, 3'(i), 1, 16'h4444);
    add(0, 0, 2, 8'h00, 16'h0000, 1, 1, 0, 1, 3'd7, 1, 16'h4444);
    add(0, 1, 2, 8'hF2, 16'h5555, 1, 1, 1, 0, 3'd0, 1, 16'h5555);
    add(0, 0, 2, 8'h00, 16'h0000, 1, 0, 0, 1, 3'd1, 1, 16'h5555);
    add_idle(2, 1, 16'h5555);
    // Clamp P=1 -> 2 bits
    add(0, 1, 1, 8'hFF, 16'h6666, 1, 1, 1, 0, 3'd0, 1, 16'h6666);
    add(0, 0, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 3'd1, 1, 16'h6666);
    add_idle(1, 1, 16'h6666);
    // Clamp P=9 -> 8 bits
    add(0, 1, 9, 8'h80, 16'h7777, 1, 1, 1, 0, 3'd0, 1, 16'h7777);
    for (int i = 1; i <= 6; i++) add(0, 0, 9, 8'h00, 16'h0000, 1, 0, 0, 0, 3'(i), 1, 16'h7777);
    add(0, 0, 9, 8'h00, 16'h0000, 1, 0, 0, 1, 3'd7, 1, 16'h7777);
    add_idle(9, 1, 16'h7777);
    // Clear beats accept in IDLE
    add(1, 1, 4, 8'h0F, 16'h8888, 0, 0, 0, 0, 3'd0, 1, 16'h7777);
    // Clear on bit 3 of a P=8 word with a pending word
    add(0, 1, 8, 8'hA5, 16'h9999, 1, 1, 1, 0, 3'd0, 1, 16'h9999);
    add(0, 1, 8, 8'hFF, 16'hAAAA, 1, 0, 0, 0, 3'd1, 0, 16'h9999);
    add(0, 0, 8, 8'h00, 16'h0000, 1, 1, 0, 0, 3'd2, 0, 16'h9999);
    add(0, 0, 8, 8'h00, 16'h0000, 1, 0, 0, 0, 3'd3, 0, 16'h9999);
    add(1, 0, 8, 8'h00, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 16'h9999);
    add_idle(8, 1, 16'h9999);
    add_idle(8, 1, 16'h9999);

    foreach (vecs[i]) begin
      clear = vecs[i].clr; in_valid = vecs[i].iv; precision = vecs[i].prec;
      in_w = vecs[i].iw; in_act = vecs[i].iact;
      @(posedge clk); #1;
      check($sformatf("v%0d valid", i), valid, vecs[i].e_valid);
      check($sformatf("v%0d w", i), w, vecs[i].e_w);
      check($sformatf("v%0d first", i), first, vecs[i].e_first);
      check($sformatf("v%0d last", i), last, vecs[i].e_last);
      check($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_ready);
      check($sformatf("v%0d act", i), act, vecs[i].e_act);
      if (vecs[i].e_valid) check($sformatf("v%0d bit_idx", i), bit_idx, vecs[i].e_idx);
    end
    clear = 1'b0; in_valid = 1'b0;

    // Async reset mid-word with a pending word
    precision = 4'd8; in_w = 8'hFF; in_act = 16'hBBBB; in_valid = 1'b1;
    @(posedge clk); #1;
    in_act = 16'hCCCC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset valid", valid, 1);
    #2 rst = 1'b0;
    #1;
    check("async rst valid", valid, 0);
    check("async rst w", w, 0);
    check("async rst first", first, 0);
    check("async rst last", last, 0);
    check("async rst bit_idx", bit_idx, 0);
    check("async rst act", act, 0);
    check("async rst in_ready", in_ready, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("post rst valid", valid, 0);
    check("post rst in_ready", in_ready, 1);

    // Three words offered during one P=8 word: third held off, none lost or reordered
    words[0] = '{4'd8, 8'h96, 16'hA001};
    words[1] = '{4'd3, 8'h05, 16'hA002};
    words[2] = '{4'd4, 8'h0C, 16'hA003};
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < int'(words[j].p); b++)
        exp_q.push_back('{words[j].w[int'(words[j].p) - 1 - b], b == 0,
                          b == int'(words[j].p) - 1, words[j].a});
    k = 0; got = 0; first_v = -1; last_v = -1; w3_edge = -1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (k < 3);
      if (k < 3) begin
        precision = words[k].p; in_w = words[k].w; in_act = words[k].a;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (k == 2) w3_edge = c;
        k++;
      end
      if (valid) begin
        if (got < exp_q.size())
          check($sformatf("stream bit %0d {w,first,last,act}", got), {w, first, last, act},
                {exp_q[got].w, exp_q[got].f, exp_q[got].l, exp_q[got].a});
        if (first_v < 0) first_v = c;
        last_v = c;
        got++;
      end
    end
    in_valid = 1'b0;
    check("stream bit count", got, 15);
    check("stream start cycle", first_v, 0);
    check("stream gapless span", last_v - first_v + 1, 15);
    check("third word accept edge", w3_edge, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
